store_narrow_unit: RTL and testbench

//  Store-path counterpart of the immediate/load sign-extender: takes a 32-bit register value plus store

---
 rtl/store_narrow_if.sv | 28 ++
 rtl/store_narrow_unit.sv | 125 ++++++++++++
 tb/tb_store_narrow_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_narrow_if.sv
// Store request / byte-wide data-memory write bundle for store_narrow_unit.
// master = MEM-stage requester plus memory model, slave = the narrowing unit.
interface store_narrow_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic              busy;
  logic              done;
  logic              addr_err;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ack,
    input  req_ready, mem_we, mem_addr, mem_wdata, busy, done, addr_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ack,
    output req_ready, mem_we, mem_addr, mem_wdata, busy, done, addr_err
  );
endinterface

// File: rtl/store_narrow_unit.sv
// Narrows a 32-bit store to SB/SH/SW and serialises it one byte per acked beat onto a byte-wide port.
// Define ALIGN_CHECK_EN to reject misaligned SH/SW; otherwise the base address is forced aligned.
module store_narrow_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  store_narrow_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       data_q;
  logic [1:0]        last_q, last_d;
  logic [1:0]        beat_q;
  logic [1:0]        lane;
  logic              accept;
  logic              illegal;
  logic              last_beat;

  assign accept    = bus.req_valid && (state_q == StIdle);
  assign last_beat = (beat_q == last_q);

  // Request decode: final beat index, effective base address and legality.
  always_comb begin
    illegal = 1'b0;
    base_d  = bus.req_addr;
    last_d  = 2'd0;
    unique case (bus.req_size)
      2'b00: last_d = 2'd0;
      2'b01: begin
        last_d = 2'd1;
`ifdef ALIGN_CHECK_EN
        illegal = bus.req_addr[0];
`else
        base_d[0] = 1'b0;
`endif
      end
      2'b10: begin
        last_d = 2'd3;
`ifdef ALIGN_CHECK_EN
        illegal = |bus.req_addr[1:0];
`else
        base_d[1:0] = 2'b00;
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = illegal ? StErr : StWrite;
        end
      end
      StWrite: begin
        if (bus.mem_ack && last_beat) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      data_q <= '0;
      last_q <= '0;
      beat_q <= '0;
    end else if (accept) begin
      base_q <= base_d;
      data_q <= bus.req_data;
      last_q <= last_d;
      beat_q <= '0;
    end else if ((state_q == StWrite) && bus.mem_ack) begin
      beat_q <= beat_q + 2'd1;
    end
  end

  // Big-endian sends the most significant used byte first.
  assign lane = BIG_ENDIAN ? (last_q - beat_q) : beat_q;

  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;
    bus.addr_err  = 1'b0;
    unique case (state_q)
      StWrite: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = base_q + ADDR_W'(beat_q);
        unique case (lane)
          2'd0:    bus.mem_wdata = data_q[7:0];
          2'd1:    bus.mem_wdata = data_q[15:8];
          2'd2:    bus.mem_wdata = data_q[23:16];
          default: bus.mem_wdata = data_q[31:24];
        endcase
      end
      StDone:  bus.done     = 1'b1;
      StErr:   bus.addr_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: a request-level model predicts the byte writes and pulses,
// a negedge compare process checks the DUT against it, and literal expectations pin the model.
module tb_store_narrow_unit;
  localparam int unsigned AW = 32;
  localparam bit          BE = 1'b1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_narrow_if #(.ADDR_W(AW)) bus ();

  store_narrow_unit #(.ADDR_W(AW), .BIG_ENDIAN(BE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_a[$];
  logic [7:0]  exp_d[$];
  logic [31:0] log_a[$];
  logic [7:0]  log_d[$];
  bit  pend_done, pend_err;
  int  acc_cyc, done_cyc, done_cnt, err_cnt;
  int  ack_delay;
  bit  stray_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Memory side: ack after ack_delay wait cycles per beat; optional stray ack while idle.
  initial begin
    int waitc;
    waitc = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_we) begin
        if (waitc >= ack_delay) begin
          bus.mem_ack = 1'b1;
          waitc = 0;
        end else begin
          bus.mem_ack = 1'b0;
          waitc++;
        end
      end else begin
        bus.mem_ack = stray_ack;
        waitc = 0;
      end
    end
  end

  // Compare process: model the request, then check every cycle.
  initial begin
    bit          prev_hold;
    logic [31:0] prev_a;
    logic [7:0]  prev_d;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_a.delete();
        exp_d.delete();
        pend_done = 1'b0;
        pend_err  = 1'b0;
        prev_hold = 1'b0;
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done_err", 32'({bus.done, bus.addr_err}), 32'd0);
      end else begin
        if (bus.req_valid && bus.req_ready) begin
          int          n;
          bit          err;
          logic [31:0] base;
          n   = 1 << bus.req_size;
          err = (bus.req_size == 2'b11);
`ifdef ALIGN_CHECK_EN
          if (!err && (bus.req_addr % n) != 0) err = 1'b1;
`endif
          base = bus.req_addr - (bus.req_addr % n);
          if (err) begin
            pend_err = 1'b1;
          end else begin
            for (int k = 0; k < n; k++) begin
              int sh;
              sh = BE ? (n - 1 - k) : k;
              exp_a.push_back(base + k);
              exp_d.push_back(8'((bus.req_data >> (8 * sh)) & 32'hFF));
            end
            pend_done = 1'b1;
          end
          acc_cyc = cyc;
        end
        if (prev_hold && bus.mem_we) begin
          chk("beat_addr_stable", bus.mem_addr, prev_a);
          chk("beat_data_stable", 32'(bus.mem_wdata), 32'(prev_d));
        end
        if (bus.mem_we && bus.mem_ack) begin
          if (exp_a.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
          end else begin
            chk("write_addr", bus.mem_addr, exp_a.pop_front());
            chk("write_data", 32'(bus.mem_wdata), 32'(exp_d.pop_front()));
          end
          log_a.push_back(bus.mem_addr);
          log_d.push_back(bus.mem_wdata);
        end
        if (pend_err) chk("no_we_on_err", 32'(bus.mem_we), 32'd0);
        if (bus.done) begin
          chk("done_expected", 32'(pend_done), 32'd1);
          chk("done_all_written", exp_a.size(), 32'd0);
          pend_done = 1'b0;
          done_cyc  = cyc;
          done_cnt++;
        end
        if (bus.addr_err) begin
          chk("err_expected", 32'(pend_err), 32'd1);
          pend_err = 1'b0;
          done_cyc = cyc;
          err_cnt++;
        end
        if (bus.done && bus.addr_err) chk("done_and_err", 32'd1, 32'd0);
        if (bus.busy == bus.req_ready) chk("busy_vs_ready", 32'(bus.busy), 32'(!bus.req_ready));
        prev_hold = bus.mem_we && !bus.mem_ack;
        prev_a    = bus.mem_addr;
        prev_d    = bus.mem_wdata;
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data  = 32'h5A5A_5A5A;
    bus.req_addr  = 32'hFFFF_0000;
  endtask

  task automatic wait_end();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done || bus.addr_err) begin
        ok = 1'b1;
        break;
      end
    end
    #2;
    if (!ok) chk("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int l0, d0, e0;
    bit hit;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = '0;
    ack_delay = 0;
    stray_ack = 1'b0;
    done_cnt  = 0;
    err_cnt   = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: SW big-endian, ack tied high
    l0 = log_a.size();
    do_store(32'h100, 32'hDEAD_BEEF, 2'b10);
    wait_end();
    chk("t1_latency", done_cyc - acc_cyc, 32'd5);
    chk("t1_a0", log_a[l0], 32'h100);
    chk("t1_d0", 32'(log_d[l0]), 32'hDE);
    chk("t1_d1", 32'(log_d[l0+1]), 32'hAD);
    chk("t1_d2", 32'(log_d[l0+2]), 32'hBE);
    chk("t1_a3", log_a[l0+3], 32'h103);
    chk("t1_d3", 32'(log_d[l0+3]), 32'hEF);

    // 2: SH with 3 wait cycles per beat
    ack_delay = 3;
    l0 = log_a.size();
    d0 = done_cnt;
    do_store(32'h202, 32'h1234_ABCD, 2'b01);
    wait_end();
    repeat (3) @(negedge clk);
    #2;
    chk("t2_latency", done_cyc - acc_cyc, 32'd9);
    chk("t2_nwrites", log_a.size() - l0, 32'd2);
    chk("t2_a0", log_a[l0], 32'h202);
    chk("t2_d0", 32'(log_d[l0]), 32'hAB);
    chk("t2_a1", log_a[l0+1], 32'h203);
    chk("t2_d1", 32'(log_d[l0+1]), 32'hCD);
    chk("t2_single_done", done_cnt - d0, 32'd1);

    // 3: SB, upper bits ignored; stray acks while idle
    ack_delay = 0;
    stray_ack = 1'b1;
    l0 = log_a.size();
    do_store(32'h7, 32'hFFFF_FF80, 2'b00);
    wait_end();
    stray_ack = 1'b0;
    chk("t3_latency", done_cyc - acc_cyc, 32'd2);
    chk("t3_nwrites", log_a.size() - l0, 32'd1);
    chk("t3_a0", log_a[l0], 32'h7);
    chk("t3_d0", 32'(log_d[l0]), 32'h80);

    // 4: misaligned SW
    l0 = log_a.size();
    e0 = err_cnt;
    do_store(32'h102, 32'h1122_3344, 2'b10);
    wait_end();
`ifdef ALIGN_CHECK_EN
    chk("t4_err", err_cnt - e0, 32'd1);
    chk("t4_nwrites", log_a.size() - l0, 32'd0);
`else
    chk("t4_err", err_cnt - e0, 32'd0);
    chk("t4_a0", log_a[l0], 32'h100);
    chk("t4_d0", 32'(log_d[l0]), 32'h11);
    chk("t4_a3", log_a[l0+3], 32'h103);
    chk("t4_d3", 32'(log_d[l0+3]), 32'h44);
`endif

    // 5: reserved size, then SW at top of address space
    l0 = log_a.size();
    e0 = err_cnt;
    do_store(32'h40, 32'h0BAD_0BAD, 2'b11);
    wait_end();
    chk("t5_rsv_err", err_cnt - e0, 32'd1);
    chk("t5_rsv_nwrites", log_a.size() - l0, 32'd0);
    l0 = log_a.size();
    do_store(32'hFFFF_FFFC, 32'hA1B2_C3D4, 2'b10);
    wait_end();
    chk("t5_wrap_err", err_cnt - e0, 32'd1);
    chk("t5_a3", log_a[l0+3], 32'hFFFF_FFFF);
    chk("t5_d3", 32'(log_d[l0+3]), 32'hD4);

    // 6: reset during beat 2 of SW
    ack_delay = 2;
    l0 = log_a.size();
    do_store(32'h300, 32'hCAFE_F00D, 2'b10);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mem_we && bus.mem_addr == 32'h302) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t6_reached_beat2", 32'(hit), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_we_now", 32'(bus.mem_we), 32'd0);
    chk("t6_busy_now", 32'(bus.busy), 32'd0);
    chk("t6_addr_now", bus.mem_addr, 32'd0);
    chk("t6_wdata_now", 32'(bus.mem_wdata), 32'd0);
    chk("t6_kept_writes", log_a.size() - l0, 32'd2);
    @(negedge clk);
    #1 rst_n = 1'b1;
    ack_delay = 0;
    l0 = log_a.size();
    do_store(32'h55, 32'h0000_0011, 2'b00);
    wait_end();
    chk("t6_after_a", log_a[l0], 32'h55);
    chk("t6_after_d", 32'(log_d[l0]), 32'h11);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
